// File: rtl/aclk_pkg.sv
// Shared types and keypad constants for the alarm-clock keypad front end.
package aclk_pkg;

   // Scanner FSM states.
   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2,
      RELEASE  = 2'd3
   } aclk_state_e;

   // Codes of the non-digit keys; digits encode as themselves.
   localparam logic [3:0] KEY_A    = 4'd10;
   localparam logic [3:0] KEY_B    = 4'd11;
   localparam logic [3:0] KEY_C    = 4'd12;
   localparam logic [3:0] KEY_D    = 4'd13;
   localparam logic [3:0] KEY_STAR = 4'd14;
   localparam logic [3:0] KEY_HASH = 4'd15;

   // Physical keypad position to key code.
   function automatic logic [3:0] keymap(input logic [1:0] row_idx, input logic [1:0] col_idx);
      logic [3:0] code;
      case ({row_idx, col_idx})
         4'b00_00: code = 4'd1;
         4'b00_01: code = 4'd2;
         4'b00_10: code = 4'd3;
         4'b00_11: code = KEY_A;
         4'b01_00: code = 4'd4;
         4'b01_01: code = 4'd5;
         4'b01_10: code = 4'd6;
         4'b01_11: code = KEY_B;
         4'b10_00: code = 4'd7;
         4'b10_01: code = 4'd8;
         4'b10_10: code = 4'd9;
         4'b10_11: code = KEY_C;
         4'b11_00: code = KEY_STAR;
         4'b11_01: code = 4'd0;
         4'b11_10: code = KEY_HASH;
         default:  code = KEY_D;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/aclk_sync2.sv
// Two-flop synchroniser for the asynchronous keypad column lines.
// Resets to all ones, i.e. "no column pulled low".
module aclk_sync2 #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   // Two back-to-back flops; only q is used downstream.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meta <= '1;
         q    <= '1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/aclk_keyscan.sv
// 4x4 keypad scanner: drives rows one at a time, debounces presses and
// releases, and emits the key code with a one-cycle digit or function strobe.
module aclk_keyscan
   import aclk_pkg::*;
#(
   parameter int SCAN_DIV     = 4,
   parameter int DEBOUNCE_CNT = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  col,
   output logic [3:0]  row,
   output logic [3:0]  key,
   output logic        shift,
   output logic        func_key,
   output aclk_state_e dbg_state
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CNT_W = ($clog2(DEBOUNCE_CNT + 1) > 0) ? $clog2(DEBOUNCE_CNT + 1) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CNT);

   logic [3:0]       col_s;
   logic [DIV_W-1:0] div;
   logic             tick;

   aclk_state_e      state, state_nxt;
   logic [3:0]       row_nxt;
   logic [1:0]       row_idx;
   logic [1:0]       cand_row, cand_row_nxt;
   logic [1:0]       cand_col, cand_col_nxt;
   logic [CNT_W-1:0] deb_cnt, deb_nxt;
   logic [CNT_W-1:0] rel_cnt, rel_nxt;
   logic             col_low;
   logic [1:0]       win_col;
   logic             confirm;
   logic [3:0]       confirm_code;

   aclk_sync2 #(.W(4)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (col),
      .q     (col_s)
   );

   assign dbg_state = state;
   assign tick      = (div == DIV_LAST);
   assign col_low   = (col_s != 4'hF);

   // Free-running scan divider; the FSM only moves on its last count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)      div <= '0;
      else if (tick)   div <= '0;
      else             div <= div + 1'b1;
   end

   // Lowest-index low column wins when several are pressed in one row.
   always_comb begin
      win_col = 2'd3;
      if      (!col_s[0]) win_col = 2'd0;
      else if (!col_s[1]) win_col = 2'd1;
      else if (!col_s[2]) win_col = 2'd2;
   end

   // Index of the row currently driven low.
   always_comb begin
      case (row)
         4'b1110: row_idx = 2'd0;
         4'b1101: row_idx = 2'd1;
         4'b1011: row_idx = 2'd2;
         default: row_idx = 2'd3;
      endcase
   end

   // Next-state logic; row rotation, counters and the confirm event all
   // change only on a scan tick.
   always_comb begin
      state_nxt    = state;
      row_nxt      = row;
      cand_row_nxt = cand_row;
      cand_col_nxt = cand_col;
      deb_nxt      = deb_cnt;
      rel_nxt      = rel_cnt;
      confirm      = 1'b0;
      confirm_code = keymap(cand_row, cand_col);
      if (tick) begin
         case (state)
            SCAN: begin
               if (!col_low) begin
                  row_nxt = {row[2:0], row[3]};
               end else begin
                  cand_row_nxt = row_idx;
                  cand_col_nxt = win_col;
                  if (DEBOUNCE_CNT == 1) begin
                     // A single sample is already a confirmed press.
                     confirm      = 1'b1;
                     confirm_code = keymap(row_idx, win_col);
                     deb_nxt      = '0;
                     state_nxt    = HELD;
                  end else begin
                     deb_nxt   = CNT_W'(1);
                     state_nxt = DEBOUNCE;
                  end
               end
            end
            DEBOUNCE: begin
               if (col_low && (win_col == cand_col)) begin
                  if ((deb_cnt + 1'b1) == CNT_DONE) begin
                     confirm   = 1'b1;
                     deb_nxt   = '0;
                     state_nxt = HELD;
                  end else begin
                     deb_nxt = deb_cnt + 1'b1;
                  end
               end else begin
                  deb_nxt   = '0;
                  row_nxt   = {row[2:0], row[3]};
                  state_nxt = SCAN;
               end
            end
            HELD: begin
               if (!col_low) begin
                  if (DEBOUNCE_CNT == 1) begin
                     row_nxt   = {row[2:0], row[3]};
                     state_nxt = SCAN;
                  end else begin
                     rel_nxt   = CNT_W'(1);
                     state_nxt = RELEASE;
                  end
               end
            end
            RELEASE: begin
               if (!col_low) begin
                  if ((rel_cnt + 1'b1) == CNT_DONE) begin
                     rel_nxt   = '0;
                     row_nxt   = {row[2:0], row[3]};
                     state_nxt = SCAN;
                  end else begin
                     rel_nxt = rel_cnt + 1'b1;
                  end
               end else begin
                  rel_nxt   = '0;
                  state_nxt = HELD;
               end
            end
            default: state_nxt = SCAN;
         endcase
      end
   end

   // State and datapath registers; strobes are high only in the cycle after
   // the confirming tick.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= SCAN;
         row      <= 4'b1110;
         cand_row <= '0;
         cand_col <= '0;
         deb_cnt  <= '0;
         rel_cnt  <= '0;
         key      <= '0;
         shift    <= 1'b0;
         func_key <= 1'b0;
      end else begin
         state    <= state_nxt;
         row      <= row_nxt;
         cand_row <= cand_row_nxt;
         cand_col <= cand_col_nxt;
         deb_cnt  <= deb_nxt;
         rel_cnt  <= rel_nxt;
         shift    <= confirm && (confirm_code <= 4'd9);
         func_key <= confirm && (confirm_code > 4'd9);
         if (confirm) key <= confirm_code;
      end
   end

endmodule

// File: tb/tb_aclk_keyscan.sv
// Bench for aclk_keyscan: a keypad model drives col from the DUT row lines,
// a scoreboard holds the strobes each press must produce.
module tb_aclk_keyscan;
   import aclk_pkg::*;

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  col, row, key;
   logic        shift, func_key;
   aclk_state_e dbg_state;

   always #5 clk = ~clk;

   aclk_keyscan #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
      .clk       (clk),
      .reset     (reset),
      .col       (col),
      .row       (row),
      .key       (key),
      .shift     (shift),
      .func_key  (func_key),
      .dbg_state (dbg_state)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk) cyc++;

   // ---------------- keypad model ----------------
   logic       pressing = 1'b0;
   logic [1:0] prow = 2'd0;
   logic [1:0] pcol = 2'd0;
   int kmap[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

   // A pressed key shorts its column to its row only while that row is low.
   always_comb begin
      col = 4'hF;
      if (pressing && (row[prow] == 1'b0)) col = ~(4'b0001 << pcol);
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- scoreboard ----------------
   logic [4:0] exp_q[$];
   int         press_cyc = 0;
   logic       prev_strobe = 1'b0;

   always @(negedge clk) begin
      logic [4:0] e;
      if (reset) begin
         if (shift || func_key) begin
            check("both_strobes", shift & func_key, 0);
            check("pulse_width", prev_strobe, 0);
            check("strobe_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("strobe_key", key, e[3:0]);
               check("strobe_kind", func_key, e[4]);
               check("latency", (cyc - press_cyc) <= 31, 1);
            end
         end
         prev_strobe = shift | func_key;
      end else begin
         prev_strobe = 1'b0;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_state(input aclk_state_e s, input int budget, input string tag);
      int n = 0;
      while (dbg_state !== s && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(tag, dbg_state, s);
   endtask

   task automatic start_press(input int r, input int c, input bit expect_strobe);
      int         code;
      logic [3:0] c4;
      @(posedge clk); #1;
      code = kmap[r*4 + c];
      c4   = code[3:0];
      prow = r[1:0];
      pcol = c[1:0];
      pressing  = 1'b1;
      press_cyc = cyc;
      if (expect_strobe) exp_q.push_back({(code > 9), c4});
   endtask

   task automatic release_key(input int rel);
      @(posedge clk); #1;
      pressing = 1'b0;
      repeat (rel) @(posedge clk);
   endtask

   task automatic press_key(input int r, input int c, input int hold, input int rel);
      start_press(r, c, 1'b1);
      repeat (hold) @(posedge clk);
      release_key(rel);
      @(negedge clk);
      check("key_hold", key, kmap[r*4 + c]);
      check("queue_drained", exp_q.size(), 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [3:0] prev;
      int n, gr, gc;

      reset = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("rst_row", row, 4'b1110);
      check("rst_key", key, 0);
      check("rst_shift", shift, 0);
      check("rst_func", func_key, 0);
      check("rst_state", dbg_state, SCAN);

      // Idle scanning: rows rotate left every 4 clocks.
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk);
      prev = row;
      n = 0;
      while (row == prev && n < 10) begin @(negedge clk); n++; end
      check("rot_first", row, 4'b1101);
      for (int i = 0; i < 5; i++) begin
         prev = row;
         n = 0;
         while (row == prev && n < 10) begin @(negedge clk); n++; end
         check("rot_period", n, 4);
         check("rot_value", row, {prev[2:0], prev[3]});
      end

      // '5' held 230 clocks: one strobe, row frozen on row 1.
      start_press(1, 1, 1'b1);
      repeat (60) @(posedge clk);
      @(negedge clk);
      check("held5_row", row, 4'b1101);
      check("held5_state", dbg_state, HELD);
      repeat (170) @(posedge clk);
      release_key(30);
      @(negedge clk);
      check("held5_key", key, 5);
      check("held5_q", exp_q.size(), 0);

      // '5' glitch seen for one tick: no strobe, scan resumes at row 2.
      start_press(1, 1, 1'b0);
      wait_state(DEBOUNCE, 40, "glitch_enter");
      pressing = 1'b0;
      wait_state(SCAN, 20, "glitch_exit");
      check("glitch_row", row, 4'b1011);
      check("glitch_key", key, 5);

      // 'D' is a function key.
      repeat (20) @(posedge clk);
      press_key(3, 3, 50, 30);

      // '1' with a release bounce that must not re-strobe.
      start_press(0, 0, 1'b1);
      wait_state(HELD, 50, "bounce_held");
      pressing = 1'b0;
      wait_state(RELEASE, 20, "bounce_release");
      pressing = 1'b1;
      wait_state(HELD, 20, "bounce_back");
      release_key(40);
      @(negedge clk);
      check("bounce_key", key, 1);
      check("bounce_q", exp_q.size(), 0);
      press_key(0, 1, 50, 30);
      press_key(3, 1, 50, 30);
      press_key(2, 0, 50, 30);

      // Reset in DEBOUNCE for '9' drops the press silently.
      start_press(2, 2, 1'b0);
      wait_state(DEBOUNCE, 40, "rst9_enter");
      @(posedge clk); #1 reset = 1'b0;
      #1;
      check("rst9_row", row, 4'b1110);
      check("rst9_key", key, 0);
      check("rst9_shift", shift, 0);
      check("rst9_state", dbg_state, SCAN);
      repeat (3) @(posedge clk);
      #1 pressing = 1'b0;
      @(posedge clk); #1 reset = 1'b1;
      repeat (20) @(posedge clk);
      press_key(2, 2, 50, 30);

      // Random presses, each optionally preceded by a short glitch.
      for (int i = 0; i < 16; i++) begin
         if ($urandom_range(0, 1) == 1) begin
            gr = $urandom_range(0, 3);
            gc = $urandom_range(0, 3);
            start_press(gr, gc, 1'b0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1 pressing = 1'b0;
            repeat (20) @(posedge clk);
         end
         press_key($urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(40, 90), $urandom_range(30, 50));
      end

      repeat (10) @(posedge clk);
      check("final_queue", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
